btn_router: RTL and testbench

BTN_ROUTER -- requirements
Module: btn_router

---
 rtl/btn_router.sv | 141 ++++++++++++++
 tb/tb_btn_router.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_router.sv
// Routes synchronised button rising-edge pulses to the one-hot selected channel.
// Optional auto-repeat for a single held button is compiled in with BTN_ROUTER_REPEAT_EN.
module btn_router #(
    parameter int NCH           = 3,
    parameter int NBTN          = 4,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                 clk,
    input  logic                 resetM,
    input  logic [NCH-1:0]       sel,
    input  logic [NBTN-1:0]      btn,
    output logic [NCH*NBTN-1:0]  btn_out,
    output logic [NCH-1:0]       active_ch
);

    logic [NBTN-1:0]     btn_meta;
    logic [NBTN-1:0]     btn_sync;
    logic [NBTN-1:0]     btn_prev;
    logic [NCH-1:0]      sel_reg;
    logic [1:0]          mask_cnt;
    logic [NBTN-1:0]     rise;
    logic [NCH-1:0]      act_next;
    logic                ch_change;
    logic                emit_ok;
    logic [NBTN-1:0]     pulse_vec;
    logic [NCH*NBTN-1:0] out_next;

    always_comb begin
        rise      = btn_sync & ~btn_prev;
        act_next  = $onehot(sel_reg) ? sel_reg : '0;
        ch_change = (act_next != active_ch);
        // Pulses only leave once the post-reset mask has expired and the channel is stable.
        emit_ok   = (mask_cnt == 2'd3) && !ch_change && (active_ch != '0);
    end

`ifdef BTN_ROUTER_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    rpt_state_t      state;
    logic [CW-1:0]   cnt;
    logic [NBTN-1:0] held;
    logic            rpt_abort;
    logic            rpt_start;
    logic            rpt_fire;

    always_comb begin
        rpt_abort = ch_change || ((btn_sync & held) == '0) || ((rise & ~held) != '0);
        rpt_start = emit_ok && (rise != '0) && $onehot(btn_sync);
        rpt_fire  = 1'b0;
        if (state == DELAY && !rpt_abort && cnt == DLY_LAST)
            rpt_fire = 1'b1;
        if (state == REPEAT && !rpt_abort && cnt == PER_LAST)
            rpt_fire = 1'b1;
        pulse_vec = emit_ok ? (rise | (rpt_fire ? held : '0)) : '0;
    end

    // The counter is cleared on every state entry and at each terminal count, so it never wraps.
    always_ff @(posedge clk) begin
        if (resetM) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rpt_start) begin
                        state <= DELAY;
                        cnt   <= '0;
                        held  <= btn_sync;
                    end
                end
                DELAY: begin
                    if (rpt_abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DLY_LAST) begin
                        state <= REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rpt_abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == PER_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
`else
    always_comb begin
        pulse_vec = emit_ok ? rise : '0;
    end
`endif

    always_comb begin
        out_next = '0;
        for (int c = 0; c < NCH; c++) begin
            if (active_ch[c])
                out_next[c*NBTN +: NBTN] = pulse_vec;
        end
    end

    // The edge register keeps tracking during the mask window so a button held through reset is swallowed.
    always_ff @(posedge clk) begin
        if (resetM) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            btn_prev  <= '0;
            sel_reg   <= '0;
            mask_cnt  <= '0;
            active_ch <= '0;
            btn_out   <= '0;
        end else begin
            btn_meta  <= btn;
            btn_sync  <= btn_meta;
            btn_prev  <= btn_sync;
            sel_reg   <= sel;
            mask_cnt  <= (mask_cnt == 2'd3) ? 2'd3 : mask_cnt + 2'd1;
            active_ch <= act_next;
            btn_out   <= out_next;
        end
    end

endmodule

// File: tb/tb_btn_router.sv
// Directed bench for btn_router with NCH=3, NBTN=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
// Auto-repeat scenarios run only when BTN_ROUTER_REPEAT_EN is defined.
module tb_btn_router;

    logic        clk;
    logic        resetM;
    logic [2:0]  sel;
    logic [3:0]  btn;
    logic [11:0] btn_out;
    logic [2:0]  active_ch;

    int n_pass;
    int n_total;
    int n_fail;

    btn_router #(
        .NCH(3),
        .NBTN(4),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .resetM(resetM),
        .sel(sel),
        .btn(btn),
        .btn_out(btn_out),
        .active_ch(active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge; inputs changed here land at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic [2:0] s, input logic [3:0] b);
        resetM = r;
        sel    = s;
        btn    = b;
    endtask

    task automatic check_output(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        n_fail  = 0;

        // Reset state
        apply_stimulus(1'b1, 3'b000, 4'b0000);
        repeat (3) step();
        check_output("reset_out", btn_out, 12'h000);
        check_output("reset_act", {9'b0, active_ch}, 12'h000);

        // Single press on channel 1
        apply_stimulus(1'b0, 3'b010, 4'b0000);
        repeat (6) step();
        check_output("ch1_act", {9'b0, active_ch}, 12'h002);
        btn = 4'b1000;
        step();
        check_output("press_lat1", btn_out, 12'h000);
        step();
        check_output("press_lat2", btn_out, 12'h000);
        step();
        check_output("press_pulse", btn_out, 12'h080);
        step();
        check_output("press_end", btn_out, 12'h000);
`ifndef BTN_ROUTER_REPEAT_EN
        for (int i = 0; i < 16; i++) begin
            step();
            check_output("held_quiet", btn_out, 12'h000);
        end
`endif
        btn = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("release_quiet", btn_out, 12'h000);
        end

        // Two buttons rising together
        btn = 4'b0110;
        repeat (2) step();
        step();
        check_output("multi_pulse", btn_out, 12'h060);
        step();
        check_output("multi_end", btn_out, 12'h000);
        btn = 4'b0000;
        repeat (5) step();

        // Non one-hot selection, then none
        sel = 3'b110;
        repeat (3) step();
        check_output("sel110_act", {9'b0, active_ch}, 12'h000);
        sel = 3'b000;
        btn = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("none_quiet", btn_out, 12'h000);
        end
        check_output("none_act", {9'b0, active_ch}, 12'h000);
        btn = 4'b0000;
        repeat (4) step();

        // Channel switch coinciding with a synchronised edge
        sel = 3'b100;
        repeat (3) step();
        check_output("ch2_act", {9'b0, active_ch}, 12'h004);
        btn = 4'b0100;
        step();
        sel = 3'b001;
        step();
        check_output("switch_pre", btn_out, 12'h000);
        step();
        check_output("switch_cycle", btn_out, 12'h000);
        check_output("switch_act", {9'b0, active_ch}, 12'h001);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("switch_discard", btn_out, 12'h000);
        end
        btn = 4'b0000;
        repeat (4) step();
        btn = 4'b0100;
        repeat (2) step();
        step();
        check_output("after_switch_pulse", btn_out, 12'h004);
        step();
        check_output("after_switch_end", btn_out, 12'h000);
        btn = 4'b0000;
        repeat (4) step();

        // Buttons held across reset release
        apply_stimulus(1'b1, 3'b001, 4'b0101);
        repeat (3) step();
        check_output("rst_hold_out", btn_out, 12'h000);
        resetM = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_output("rst_hold_quiet", btn_out, 12'h000);
        end
        check_output("rst_hold_act", {9'b0, active_ch}, 12'h001);
        btn = 4'b0000;
        repeat (3) step();
        btn = 4'b0001;
        repeat (2) step();
        step();
        check_output("rst_repress_pulse", btn_out, 12'h001);
        step();
        check_output("rst_repress_end", btn_out, 12'h000);
        btn = 4'b0000;
        repeat (4) step();

`ifdef BTN_ROUTER_REPEAT_EN
        // Hold btn[3]: edge pulse, then +8, then every 4, stop after release
        btn = 4'b1000;
        repeat (2) step();
        step();
        check_output("rpt_edge", btn_out, 12'h008);
        for (int i = 1; i <= 40; i++) begin
            logic [11:0] exp_v;
            step();
            exp_v = (i <= 31 && (i == 8 || (i > 8 && ((i - 8) % 4) == 0))) ? 12'h008 : 12'h000;
            check_output("rpt_seq", btn_out, exp_v);
            if (i == 29)
                btn = 4'b0000;
        end

        // Second button pressed during DELAY aborts the repeat
        btn = 4'b1000;
        repeat (2) step();
        step();
        check_output("abort_edge", btn_out, 12'h008);
        for (int i = 1; i <= 20; i++) begin
            step();
            check_output("abort_seq", btn_out, (i == 6) ? 12'h002 : 12'h000);
            if (i == 3)
                btn = 4'b1010;
        end
        btn = 4'b0000;
        repeat (5) step();

        // Reset asserted during DELAY
        btn = 4'b1000;
        repeat (2) step();
        step();
        check_output("rstd_edge", btn_out, 12'h008);
        for (int i = 1; i <= 20; i++) begin
            step();
            check_output("rstd_seq", btn_out, 12'h000);
            if (i == 3)
                resetM = 1'b1;
            if (i == 4)
                resetM = 1'b0;
        end
        check_output("rstd_act", {9'b0, active_ch}, 12'h001);
        btn = 4'b0000;
        repeat (4) step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
